// File: rtl/prng_pkg.sv
// Shared types and defaults for the PRNG word packer slice.
// Optional feature macro used by the top: PRNG_HEALTH_EN.
package prng_pkg;

   localparam int WORD_BYTES_DEF = 4;
   localparam int FIFO_DEPTH_DEF = 4;
   localparam int REP_LIMIT_DEF  = 8;
   localparam int DROP_CNT_W     = 8;

   typedef logic [7:0] byte_t;

   function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
      return (v == {DROP_CNT_W{1'b1}}) ? v : v + {{(DROP_CNT_W-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/prng_word_fifo.sv
// Synchronous first-word-fall-through FIFO with registered head, valid and fill.
// The head register holds its last value when the FIFO runs empty.
module prng_word_fifo #(
   parameter  int W     = 32,
   parameter  int DEPTH = 4,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          push,
   input  logic [W-1:0]  wdata,
   input  logic          pop,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] fill,
   output logic          head_valid,
   output logic [W-1:0]  head_data
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_q, wr_d, rd_q, rd_d, rd_nxt_s;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  head_q, head_d;
   logic          vld_q, vld_d;
   logic          do_push_s, do_pop_s;

   assign full       = (cnt_q == CW'(DEPTH));
   assign empty      = (cnt_q == {CW{1'b0}});
   assign fill       = cnt_q;
   assign head_valid = vld_q;
   assign head_data  = head_q;

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_pop_s  = pop & ~empty & ~flush;
   assign do_push_s = push & (~full | do_pop_s) & ~flush;
   assign rd_nxt_s  = rd_q + 1'b1;

   always_comb begin
      wr_d   = wr_q;
      rd_d   = rd_q;
      cnt_d  = cnt_q;
      head_d = head_q;
      if (flush) begin
         wr_d  = {PW{1'b0}};
         rd_d  = {PW{1'b0}};
         cnt_d = {CW{1'b0}};
      end else begin
         if (do_push_s) wr_d = wr_q + 1'b1;
         else           wr_d = wr_q;
         if (do_pop_s)  rd_d = rd_nxt_s;
         else           rd_d = rd_q;
         case ({do_push_s, do_pop_s})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
         // The next head is either the incoming word (FIFO drains to it) or a stored entry.
         if (cnt_d == {CW{1'b0}})                        head_d = head_q;
         else if (empty || (do_pop_s && cnt_q == CW'(1))) head_d = wdata;
         else if (do_pop_s)                              head_d = mem_q[rd_nxt_s];
         else                                            head_d = mem_q[rd_q];
      end
      vld_d = (cnt_d != {CW{1'b0}});
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q   <= {PW{1'b0}};
         rd_q   <= {PW{1'b0}};
         cnt_q  <= {CW{1'b0}};
         head_q <= {W{1'b0}};
         vld_q  <= 1'b0;
      end else begin
         wr_q   <= wr_d;
         rd_q   <= rd_d;
         cnt_q  <= cnt_d;
         head_q <= head_d;
         vld_q  <= vld_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push_s) mem_q[wr_q] <= wdata;
   end

endmodule

// File: rtl/prng_word_packer.sv
// Packs PRNG bytes little-endian into words, buffers them and counts overflow drops.
// Define PRNG_HEALTH_EN to add the sticky repetition-count health test.
module prng_word_packer
   import prng_pkg::*;
#(
   parameter  int WORD_BYTES = WORD_BYTES_DEF,
   parameter  int FIFO_DEPTH = FIFO_DEPTH_DEF,
   parameter  int REP_LIMIT  = REP_LIMIT_DEF,
   localparam int WORD_W     = 8 * WORD_BYTES,
   localparam int FILL_W     = $clog2(FIFO_DEPTH) + 1,
   localparam int IDX_W      = $clog2(WORD_BYTES)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   input  logic [7:0]            byte_in,
   output logic                  out_valid,
   output logic [WORD_W-1:0]     out_data,
   input  logic                  out_ready,
   output logic [FILL_W-1:0]     fill,
   output logic [DROP_CNT_W-1:0] drop_cnt,
   output logic                  overflow,
   output logic                  health_fail
);

   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [WORD_W-1:0]     word_q, word_d, word_asm_s;
   logic [DROP_CNT_W-1:0] drop_q, drop_d;
   logic                  ovf_q, ovf_d;
   logic                  accept_s, last_s, push_s, drop_s, block_s;
   logic                  full_s, empty_s;

   assign last_s   = (idx_q == IDX_W'(WORD_BYTES - 1));
   assign accept_s = in_valid & ~flush & ~block_s;
   assign push_s   = accept_s & last_s;
   assign drop_s   = push_s & full_s & ~(out_ready & ~empty_s);

   always_comb begin
      word_asm_s = word_q;
      word_asm_s[8*idx_q +: 8] = byte_in;
      idx_d  = idx_q;
      word_d = word_q;
      if (flush) begin
         idx_d  = {IDX_W{1'b0}};
         word_d = {WORD_W{1'b0}};
      end else if (accept_s && last_s) begin
         idx_d  = {IDX_W{1'b0}};
         word_d = {WORD_W{1'b0}};
      end else if (accept_s) begin
         idx_d  = idx_q + 1'b1;
         word_d = word_asm_s;
      end else begin
         idx_d  = idx_q;
         word_d = word_q;
      end
      if (drop_s) begin
         drop_d = sat_inc(drop_q);
         ovf_d  = 1'b1;
      end else begin
         drop_d = drop_q;
         ovf_d  = ovf_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q  <= {IDX_W{1'b0}};
         word_q <= {WORD_W{1'b0}};
         drop_q <= {DROP_CNT_W{1'b0}};
         ovf_q  <= 1'b0;
      end else begin
         idx_q  <= idx_d;
         word_q <= word_d;
         drop_q <= drop_d;
         ovf_q  <= ovf_d;
      end
   end

   assign drop_cnt = drop_q;
   assign overflow = ovf_q;

`ifdef PRNG_HEALTH_EN
   logic [7:0] rep_q, rep_d;
   byte_t      last_byte_q, last_byte_d;
   logic       hf_q, hf_d;

   // Bytes arriving after the trip are discarded, so the counter freezes with the flag.
   always_comb begin
      rep_d       = rep_q;
      last_byte_d = last_byte_q;
      hf_d        = hf_q;
      if (in_valid && !flush && !hf_q) begin
         if (rep_q != 8'd0 && byte_in == last_byte_q) rep_d = rep_q + 8'd1;
         else                                         rep_d = 8'd1;
         last_byte_d = byte_in;
         hf_d        = (rep_d >= 8'(REP_LIMIT));
      end else begin
         rep_d = rep_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rep_q       <= 8'd0;
         last_byte_q <= 8'd0;
         hf_q        <= 1'b0;
      end else begin
         rep_q       <= rep_d;
         last_byte_q <= last_byte_d;
         hf_q        <= hf_d;
      end
   end

   assign block_s     = hf_q;
   assign health_fail = hf_q;
`else
   assign block_s     = 1'b0;
   assign health_fail = 1'b0;
`endif

   prng_word_fifo #(
      .W     (WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .push       (push_s),
      .wdata      (word_asm_s),
      .pop        (out_ready),
      .full       (full_s),
      .empty      (empty_s),
      .fill       (fill),
      .head_valid (out_valid),
      .head_data  (out_data)
   );

endmodule

// File: tb/tb_prng_word_packer.sv
// Directed self-checking bench for prng_word_packer (default 4-byte words, depth 4).
// Expectations for the health scenario follow PRNG_HEALTH_EN when it is defined.
module tb_prng_word_packer;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, out_ready;
   logic [7:0]  byte_in;
   logic        out_valid, overflow, health_fail;
   logic [31:0] out_data;
   logic [2:0]  fill;
   logic [7:0]  drop_cnt;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   prng_word_packer dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .in_valid    (in_valid),
      .byte_in     (byte_in),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_ready   (out_ready),
      .fill        (fill),
      .drop_cnt    (drop_cnt),
      .overflow    (overflow),
      .health_fail (health_fail)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      in_valid = 1'b1;
      byte_in  = b;
      step();
      in_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
   endtask

   task automatic do_reset();
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; byte_in = 8'h00;
      step(); step();
      rst = 1'b0;
   endtask

   function automatic logic [31:0] word_of(input int i);
      logic [7:0] b0, b1, b2, b3;
      b0 = 8'(16*i + 1); b1 = 8'(16*i + 2); b2 = 8'(16*i + 3); b3 = 8'(16*i + 4);
      return {b3, b2, b1, b0};
   endfunction

   task automatic test_reset();
      do_reset();
      vectors++;
      if ({out_valid, out_data, fill, drop_cnt, overflow, health_fail} !== 46'd0) begin
         miscompares++;
         $display("FAIL reset_state: got v=%b d=%h f=%0d dc=%0d o=%b h=%b, want all 0",
                  out_valid, out_data, fill, drop_cnt, overflow, health_fail);
      end
   endtask

   task automatic test_pack();
      do_reset();
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++; $display("FAIL pack_partial_valid: got %b want 0", out_valid);
      end
      send_byte(8'h44);
      vectors++;
      if (out_valid !== 1'b1 || out_data !== 32'h44332211 || fill !== 3'd1) begin
         miscompares++;
         $display("FAIL pack_word: got v=%b d=%h f=%0d want v=1 d=44332211 f=1", out_valid, out_data, fill);
      end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < 5; i++) send_word(word_of(i));
      vectors++;
      if (fill !== 3'd4 || drop_cnt !== 8'd1 || overflow !== 1'b1) begin
         miscompares++;
         $display("FAIL overflow_state: got f=%0d dc=%0d o=%b want f=4 dc=1 o=1", fill, drop_cnt, overflow);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (out_valid !== 1'b1 || out_data !== word_of(i)) begin
            miscompares++;
            $display("FAIL drain_word%0d: got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, word_of(i));
         end
         step();
      end
      step();
      out_ready = 1'b0;
      vectors++;
      if (out_valid !== 1'b0 || fill !== 3'd0 || out_data !== word_of(3)) begin
         miscompares++;
         $display("FAIL pop_empty: got v=%b f=%0d d=%h want v=0 f=0 d=%h", out_valid, fill, out_data, word_of(3));
      end
   endtask

   task automatic test_push_pop_full();
      logic [31:0] w4;
      do_reset();
      for (int i = 0; i < 4; i++) send_word(word_of(i));
      w4 = word_of(4);
      for (int k = 0; k < 3; k++) send_byte(w4[8*k +: 8]);
      out_ready = 1'b1;
      send_byte(w4[31:24]);
      out_ready = 1'b0;
      vectors++;
      if (fill !== 3'd4 || drop_cnt !== 8'd0 || overflow !== 1'b0 || out_data !== word_of(1)) begin
         miscompares++;
         $display("FAIL full_push_pop: got f=%0d dc=%0d o=%b d=%h want f=4 dc=0 o=0 d=%h",
                  fill, drop_cnt, overflow, out_data, word_of(1));
      end
      out_ready = 1'b1;
      for (int i = 1; i < 5; i++) begin
         vectors++;
         if (out_valid !== 1'b1 || out_data !== word_of(i)) begin
            miscompares++;
            $display("FAIL full_drain%0d: got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, word_of(i));
         end
         step();
      end
      out_ready = 1'b0;
   endtask

   task automatic test_flush();
      do_reset();
      send_word(32'h0D0C0B0A);
      send_byte(8'hAA); send_byte(8'hBB);
      flush = 1'b1; in_valid = 1'b1; byte_in = 8'hCC; out_ready = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      vectors++;
      if (fill !== 3'd0 || out_valid !== 1'b0) begin
         miscompares++; $display("FAIL flush_empty: got f=%0d v=%b want f=0 v=0", fill, out_valid);
      end
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
      vectors++;
      if (out_data !== 32'h04030201 || fill !== 3'd1 || out_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL flush_repack: got d=%h f=%0d v=%b want d=04030201 f=1 v=1", out_data, fill, out_valid);
      end
   endtask

   task automatic test_health();
      logic [2:0] exp_fill;
      logic       exp_hf;
      do_reset();
      for (int i = 0; i < 8; i++) send_byte(8'h5A);
`ifdef PRNG_HEALTH_EN
      exp_hf = 1'b1;
`else
      exp_hf = 1'b0;
`endif
      vectors++;
      if (fill !== 3'd2 || health_fail !== exp_hf || out_data !== 32'h5A5A5A5A) begin
         miscompares++;
         $display("FAIL health_first8: got f=%0d h=%b d=%h want f=2 h=%b d=5a5a5a5a", fill, health_fail, out_data, exp_hf);
      end
      for (int i = 0; i < 8; i++) send_byte(8'h5A);
`ifdef PRNG_HEALTH_EN
      exp_fill = 3'd2;
`else
      exp_fill = 3'd4;
`endif
      vectors++;
      if (fill !== exp_fill || health_fail !== exp_hf) begin
         miscompares++;
         $display("FAIL health_next8: got f=%0d h=%b want f=%0d h=%b", fill, health_fail, exp_fill, exp_hf);
      end
   endtask

   task automatic test_saturate_and_reset();
      do_reset();
      for (int i = 0; i < 304; i++) send_word(32'h80706050 + 32'(i));
      vectors++;
      if (drop_cnt !== 8'd255 || overflow !== 1'b1 || fill !== 3'd4) begin
         miscompares++;
         $display("FAIL drop_saturate: got dc=%0d o=%b f=%0d want dc=255 o=1 f=4", drop_cnt, overflow, fill);
      end
      send_byte(8'hE1); send_byte(8'hE2);
      do_reset();
      vectors++;
      if ({out_valid, out_data, fill, drop_cnt, overflow, health_fail} !== 46'd0) begin
         miscompares++;
         $display("FAIL midword_reset: got v=%b d=%h f=%0d dc=%0d o=%b h=%b, want all 0",
                  out_valid, out_data, fill, drop_cnt, overflow, health_fail);
      end
      send_word(32'hC4C3C2C1);
      vectors++;
      if (out_data !== 32'hC4C3C2C1 || fill !== 3'd1) begin
         miscompares++;
         $display("FAIL post_reset_word: got d=%h f=%0d want d=c4c3c2c1 f=1", out_data, fill);
      end
   endtask

   initial begin
      test_reset();
      test_pack();
      test_overflow();
      test_push_pop_full();
      test_flush();
      test_health();
      test_saturate_and_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
